// File: rtl/exe_stage_unit.sv
// Execute stage of the ARM-subset pipeline: Val2 generation, ALU, NZCV status
// register, branch target and the EXE/MEM pipeline register.
module exe_stage_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              b_in,
   input  logic              s_in,
   input  logic              imm_in,
   input  logic [3:0]        exe_cmd_in,
   input  logic [DATA_W-1:0] val_rn_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic [3:0]        dest_in,
   input  logic [11:0]       shift_operand_in,
   input  logic [23:0]       signed_imm_24_in,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_addr,
   output logic [3:0]        status_out,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic              mem_w_en_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] val_rm_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [3:0]        dest_out
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   logic [DATA_W-1:0]   val2;
   logic [2*DATA_W-1:0] imm_rot_wide;
   logic [2*DATA_W-1:0] rm_rot_wide;
   logic [4:0]          shift_amt;
   logic [4:0]          imm_rot_amt;
   logic [DATA_W-1:0]   imm_zext;

   logic [DATA_W-1:0]   alu_result;
   logic [DATA_W-1:0]   addend_b;
   logic                carry_in;
   logic [DATA_W:0]     sum;
   logic                is_arith;
   logic                cmd_valid;
   logic [3:0]          new_status;

   // Rotations are taken from a doubled word so an amount of zero needs no special case.
   always_comb begin
      shift_amt    = shift_operand_in[11:7];
      imm_rot_amt  = {shift_operand_in[11:8], 1'b0};
      imm_zext     = {{(DATA_W-8){1'b0}}, shift_operand_in[7:0]};
      imm_rot_wide = {imm_zext, imm_zext} >> imm_rot_amt;
      rm_rot_wide  = {val_rm_in, val_rm_in} >> shift_amt;
      val2         = '0;
      if (mem_r_en_in || mem_w_en_in) begin
         val2 = {{(DATA_W-12){1'b0}}, shift_operand_in};
      end else if (imm_in) begin
         val2 = imm_rot_wide[DATA_W-1:0];
      end else begin
         case (shift_operand_in[6:5])
            2'b00:   val2 = val_rm_in << shift_amt;
            2'b01:   val2 = val_rm_in >> shift_amt;
            2'b10:   val2 = DATA_W'($signed(val_rm_in) >>> shift_amt);
            default: val2 = rm_rot_wide[DATA_W-1:0];
         endcase
      end
   end

   // Subtraction reuses the adder with an inverted operand and a carry-in.
   always_comb begin
      addend_b   = val2;
      carry_in   = 1'b0;
      is_arith   = 1'b0;
      cmd_valid  = 1'b1;
      alu_result = '0;
      case (exe_cmd_in)
         CMD_ADD: is_arith = 1'b1;
         CMD_ADC: begin is_arith = 1'b1; carry_in = status_out[1]; end
         CMD_SUB: begin is_arith = 1'b1; addend_b = ~val2; carry_in = 1'b1; end
         CMD_SBC: begin is_arith = 1'b1; addend_b = ~val2; carry_in = status_out[1]; end
         default: ;
      endcase
      sum = {1'b0, val_rn_in} + {1'b0, addend_b} + {{DATA_W{1'b0}}, carry_in};
      case (exe_cmd_in)
         CMD_MOV: alu_result = val2;
         CMD_MVN: alu_result = ~val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_result = sum[DATA_W-1:0];
         CMD_AND: alu_result = val_rn_in & val2;
         CMD_ORR: alu_result = val_rn_in | val2;
         CMD_EOR: alu_result = val_rn_in ^ val2;
         default: cmd_valid = 1'b0;
      endcase
      new_status = status_out;
      if (cmd_valid) begin
         new_status[3] = alu_result[DATA_W-1];
         new_status[2] = (alu_result == '0);
         if (is_arith) begin
            new_status[1] = sum[DATA_W];
            new_status[0] = (val_rn_in[DATA_W-1] == addend_b[DATA_W-1]) &&
                            (alu_result[DATA_W-1] != val_rn_in[DATA_W-1]);
         end
      end
   end

   assign branch_taken = b_in;
   assign branch_addr  = pc_in + {{(DATA_W-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_out <= '0;
      end else if (s_in && !freeze) begin
         status_out <= new_status;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_out      <= 1'b0;
         mem_r_en_out   <= 1'b0;
         mem_w_en_out   <= 1'b0;
         alu_result_out <= '0;
         val_rm_out     <= '0;
         pc_out         <= '0;
         dest_out       <= '0;
      end else if (!freeze) begin
         wb_en_out      <= wb_en_in;
         mem_r_en_out   <= mem_r_en_in;
         mem_w_en_out   <= mem_w_en_in;
         alu_result_out <= alu_result;
         val_rm_out     <= val_rm_in;
         pc_out         <= pc_in;
         dest_out       <= dest_in;
      end
   end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed testbench for exe_stage_unit: reset, shifter, ALU flags, carry chaining,
// freeze and branch target, with hand-computed expectations.
module tb_exe_stage_unit;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic [31:0] pc_in;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
   logic [3:0]  exe_cmd_in;
   logic [31:0] val_rn_in, val_rm_in;
   logic [3:0]  dest_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm_24_in;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  status_out;
   logic        wb_en_out, mem_r_en_out, mem_w_en_out;
   logic [31:0] alu_result_out, val_rm_out, pc_out;
   logic [3:0]  dest_out;

   int total = 0;
   int bad   = 0;

   exe_stage_unit #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
      .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
      .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
      .branch_taken(branch_taken), .branch_addr(branch_addr), .status_out(status_out),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .alu_result_out(alu_result_out), .val_rm_out(val_rm_out), .pc_out(pc_out),
      .dest_out(dest_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      freeze = 0; pc_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
      b_in = 0; s_in = 0; imm_in = 0; exe_cmd_in = 4'b0000; val_rn_in = 0;
      val_rm_in = 0; dest_in = 0; shift_operand_in = 0; signed_imm_24_in = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      freeze = 0; pc_in = 32'hDEADBEEF; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1;
      b_in = 1; s_in = 1; imm_in = 0; exe_cmd_in = 4'b0100; val_rn_in = 32'h1234;
      val_rm_in = 32'hFFFF0000; dest_in = 4'hA; shift_operand_in = 12'h5A5;
      signed_imm_24_in = 24'h123456;
      repeat (3) step();
      total++;
      if ({wb_en_out, mem_r_en_out, mem_w_en_out, alu_result_out, val_rm_out, pc_out,
           dest_out, status_out} !== '0) begin
         bad++;
         $display("FAIL reset_hold got alu=%h pc=%h rm=%h dest=%h st=%b required all zero",
                  alu_result_out, pc_out, val_rm_out, dest_out, status_out);
      end
      rst = 1;
      set_idle();
      pc_in = 32'h44; dest_in = 4'h3; wb_en_in = 1; exe_cmd_in = 4'b0001;
      imm_in = 1; shift_operand_in = 12'h001; val_rm_in = 32'hCAFE0001;
      step();
      total++;
      if ({pc_out, dest_out, wb_en_out, alu_result_out, val_rm_out, status_out} !==
          {32'h44, 4'h3, 1'b1, 32'h1, 32'hCAFE0001, 4'b0000}) begin
         bad++;
         $display("FAIL reset_release got pc=%h dest=%h wb=%b alu=%h rm=%h st=%b required pc=44 dest=3 wb=1 alu=1 rm=cafe0001 st=0000",
                  pc_out, dest_out, wb_en_out, alu_result_out, val_rm_out, status_out);
      end
   endtask

   task automatic test_imm_rotate();
      set_idle();
      imm_in = 1; shift_operand_in = 12'h4FF; exe_cmd_in = 4'b0001; s_in = 1;
      step();
      total++;
      if (alu_result_out !== 32'hFF000000) begin
         bad++;
         $display("FAIL imm_rotate_result got=%h required=ff000000", alu_result_out);
      end
      total++;
      if (status_out !== 4'b1000) begin
         bad++;
         $display("FAIL imm_rotate_status got=%b required=1000", status_out);
      end
   endtask

   task automatic test_shifts();
      logic [11:0] ops [4];
      logic [31:0] exp [4];
      ops[0] = 12'h240; exp[0] = 32'hF8000001;
      ops[1] = 12'h0E0; exp[1] = 32'h40000001;
      ops[2] = 12'h080; exp[2] = 32'h00000001;
      ops[3] = 12'h220; exp[3] = 32'h08000001;
      for (int i = 0; i < 4; i++) begin
         set_idle();
         exe_cmd_in = 4'b0010; val_rn_in = 32'h1; val_rm_in = 32'h80000000;
         shift_operand_in = ops[i];
         step();
         total++;
         if (alu_result_out !== exp[i]) begin
            bad++;
            $display("FAIL shift_%0d op=%h got=%h required=%h", i, ops[i], alu_result_out, exp[i]);
         end
      end
      total++;
      if (status_out !== 4'b1000) begin
         bad++;
         $display("FAIL shift_status_hold got=%b required=1000", status_out);
      end
   endtask

   task automatic test_sub_cmp();
      set_idle();
      exe_cmd_in = 4'b0100; val_rn_in = 32'd5; imm_in = 1; shift_operand_in = 12'h005; s_in = 1;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h0, 4'b0110}) begin
         bad++;
         $display("FAIL sub_cmp got result=%h st=%b required result=0 st=0110", alu_result_out, status_out);
      end
   endtask

   task automatic test_add_overflow();
      set_idle();
      exe_cmd_in = 4'b0010; val_rn_in = 32'h7FFFFFFF; imm_in = 1; shift_operand_in = 12'h001; s_in = 1;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h80000000, 4'b1001}) begin
         bad++;
         $display("FAIL add_overflow got result=%h st=%b required result=80000000 st=1001", alu_result_out, status_out);
      end
   endtask

   task automatic test_back_to_back();
      // SUB 5-5 sets C, next-cycle ADC 1+1 must consume it
      set_idle();
      exe_cmd_in = 4'b0100; val_rn_in = 32'd5; imm_in = 1; shift_operand_in = 12'h005; s_in = 1;
      step();
      exe_cmd_in = 4'b0011; val_rn_in = 32'd1; shift_operand_in = 12'h001;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h3, 4'b0000}) begin
         bad++;
         $display("FAIL adc_chain got result=%h st=%b required result=3 st=0000", alu_result_out, status_out);
      end
      // ADC producing carry out, then ADC 0+0+C
      val_rn_in = 32'hFFFFFFFF; shift_operand_in = 12'h001;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h0, 4'b0110}) begin
         bad++;
         $display("FAIL adc_carry_out got result=%h st=%b required result=0 st=0110", alu_result_out, status_out);
      end
      val_rn_in = 32'h0; shift_operand_in = 12'h000;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h1, 4'b0000}) begin
         bad++;
         $display("FAIL adc_carry_in got result=%h st=%b required result=1 st=0000", alu_result_out, status_out);
      end
      // unused command: result 0, flags must not move even though s=1
      exe_cmd_in = 4'b0000; val_rn_in = 32'h9;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h0, 4'b0000}) begin
         bad++;
         $display("FAIL invalid_cmd got result=%h st=%b required result=0 st=0000", alu_result_out, status_out);
      end
      // SBC: 10 - 3 - !C with C=0 -> 6, no borrow so C=1
      exe_cmd_in = 4'b0101; val_rn_in = 32'd10; shift_operand_in = 12'h003;
      step();
      total++;
      if ({alu_result_out, status_out} !== {32'h6, 4'b0010}) begin
         bad++;
         $display("FAIL sbc got result=%h st=%b required result=6 st=0010", alu_result_out, status_out);
      end
   endtask

   task automatic test_mem_freeze();
      set_idle();
      mem_w_en_in = 1; imm_in = 1; exe_cmd_in = 4'b0010; val_rn_in = 32'h100;
      shift_operand_in = 12'hFFF; pc_in = 32'h60; dest_in = 4'h7; val_rm_in = 32'h55;
      step();
      total++;
      if ({alu_result_out, mem_w_en_out, mem_r_en_out, wb_en_out} !== {32'h10FF, 3'b100}) begin
         bad++;
         $display("FAIL mem_offset got alu=%h mw=%b mr=%b wb=%b required alu=10ff mw=1 mr=0 wb=0",
                  alu_result_out, mem_w_en_out, mem_r_en_out, wb_en_out);
      end
      set_idle();
      freeze = 1; s_in = 1; exe_cmd_in = 4'b0100; val_rn_in = 32'd5; imm_in = 1;
      shift_operand_in = 12'h005; wb_en_in = 1; pc_in = 32'h99; dest_in = 4'h1; val_rm_in = 32'hAA;
      repeat (2) step();
      total++;
      if ({alu_result_out, mem_w_en_out, wb_en_out, pc_out, dest_out, val_rm_out, status_out} !==
          {32'h10FF, 1'b1, 1'b0, 32'h60, 4'h7, 32'h55, 4'b0010}) begin
         bad++;
         $display("FAIL freeze_hold got alu=%h mw=%b wb=%b pc=%h dest=%h rm=%h st=%b required alu=10ff mw=1 wb=0 pc=60 dest=7 rm=55 st=0010",
                  alu_result_out, mem_w_en_out, wb_en_out, pc_out, dest_out, val_rm_out, status_out);
      end
      freeze = 0;
      step();
      total++;
      if ({alu_result_out, wb_en_out, pc_out, status_out} !== {32'h0, 1'b1, 32'h99, 4'b0110}) begin
         bad++;
         $display("FAIL freeze_release got alu=%h wb=%b pc=%h st=%b required alu=0 wb=1 pc=99 st=0110",
                  alu_result_out, wb_en_out, pc_out, status_out);
      end
   endtask

   task automatic test_branch();
      set_idle();
      b_in = 1; pc_in = 32'h20; signed_imm_24_in = 24'hFFFFFE; freeze = 1;
      #1;
      total++;
      if ({branch_taken, branch_addr} !== {1'b1, 32'h18}) begin
         bad++;
         $display("FAIL branch_back got taken=%b addr=%h required taken=1 addr=18", branch_taken, branch_addr);
      end
      b_in = 0; pc_in = 32'h1000; signed_imm_24_in = 24'h000004; freeze = 0;
      #1;
      total++;
      if ({branch_taken, branch_addr} !== {1'b0, 32'h1010}) begin
         bad++;
         $display("FAIL branch_fwd got taken=%b addr=%h required taken=0 addr=1010", branch_taken, branch_addr);
      end
      step();
   endtask

   task automatic test_reset_mid();
      set_idle();
      exe_cmd_in = 4'b1001; s_in = 1; wb_en_in = 1; pc_in = 32'h80; dest_in = 4'hF;
      step();
      #2;
      rst = 0;
      #1;
      total++;
      if ({wb_en_out, alu_result_out, pc_out, dest_out, status_out} !== '0) begin
         bad++;
         $display("FAIL reset_async got wb=%b alu=%h pc=%h dest=%h st=%b required all zero",
                  wb_en_out, alu_result_out, pc_out, dest_out, status_out);
      end
      step();
      total++;
      if ({wb_en_out, alu_result_out, pc_out, status_out} !== '0) begin
         bad++;
         $display("FAIL reset_mid_hold got wb=%b alu=%h pc=%h st=%b required all zero",
                  wb_en_out, alu_result_out, pc_out, status_out);
      end
      rst = 1;
   endtask

   initial begin
      rst = 0;
      set_idle();
      test_reset();
      test_imm_rotate();
      test_shifts();
      test_sub_cmp();
      test_add_overflow();
      test_back_to_back();
      test_mem_freeze();
      test_branch();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM-subset pipeline; sits directly downstream of the ID/EXE pipeline register.
- Combinationally generates Val2, the ALU result and the branch target.
- Owns the 4-bit NZCV status register, which feeds the decode-stage condition check.
- Registers its results into the EXE/MEM pipeline boundary, which drives the memory stage.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  when 1, all state holds (memory stall)
- pc_in  in  32  PC of the instruction in EXE (already PC+4)
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  in  1 each  control bits from ID/EXE
- exe_cmd_in  in  4  ALU command
- val_rn_in, val_rm_in  in  32  register operands
- dest_in  in  4  destination register
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- branch_taken  out  1  combinational; equals b_in
- branch_addr  out  32  combinational; pc_in + (sign_extend(signed_imm_24_in) << 2), mod 2^32
- status_out  out  4  registered {N,Z,C,V}
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered control bits
- alu_result_out, val_rm_out, pc_out  out  32 each  registered values
- dest_out  out  4  registered destination

Behaviour:
- Reset (rst=0, asynchronous): every registered output and status_out go to 0 immediately; they stay 0 until the first clock edge after rst=1.
- Reset mid-operation discards in-flight results; nothing is retained.
- Val2 selection, in priority order:
  - mem_r_en_in|mem_w_en_in: Val2 = zero-extended shift_operand_in[11:0].
  - else imm_in: Val2 = {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8] (0..30).
  - else: Val2 = val_rm_in shifted by shift_operand_in[11:7] (0..31), type per shift_operand_in[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes val_rm_in unchanged for all four types; no RRX.
- ALU, with Cin = status_out[1]:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+Cin
  - 0100 SUB/CMP: Rn+~Val2+1
  - 0101 SBC: Rn+~Val2+Cin
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - any other code: result 0 and flags unchanged.
- Flags: N = result[31]; Z = (result == 0).
  - Arithmetic ops: C = bit 32 of the 33-bit sum (SUB C=1 means no borrow); V = signed overflow of the two addends.
  - Logical ops and MOV/MVN: C and V keep their current values.
- Status update: at posedge, if s_in=1 and freeze=0, status_out <= new {N,Z,C,V}; otherwise it holds. b_in has no effect on status.
- Pipeline register: at posedge with freeze=0, capture wb_en, mem_r_en, mem_w_en, alu result, val_rm_in, dest_in and pc_in (one-cycle latency). With freeze=1, all registered outputs hold.
- A new status value is visible on status_out the cycle after the flag-setting instruction leaves EXE, so back-to-back ADCs chain their carry correctly.
- branch_taken and branch_addr are unaffected by freeze.

Test Plan:
- Reset: hold rst=0, toggle clk, drive junk inputs -> all registered outputs = 0, status_out = 0000. Release rst -> first edge captures inputs.
- Immediate rotate: imm=1, shift_operand=12'h4FF, MOV, s=1 -> alu_result_out = 32'hFF000000, status = 1000 (N=1).
- Register shifts, ADD with val_rn = 1, val_rm = 32'h80000000, imm=0:
  - ASR #4 (shift_operand=12'h240) -> result 32'hF8000001.
  - ROR #1 (12'h0E0) -> 32'h40000001.
- SUB/CMP: val_rn = 5, Val2 = 5, s=1 -> result 0, status = 0110 (Z=1, C=1).
- ADD overflow: 32'h7FFFFFFF + 1, s=1 -> result 32'h80000000, status = 1001.
- ADC chain: flags C=1 from a prior op, then ADC 1+1 -> result 3.
- Memory offset and freeze:
  - STR with shift_operand = 12'hFFF, val_rn = 32'h100, ADD -> alu_result_out = 32'h10FF, mem_w_en_out = 1.
  - Raise freeze for 2 cycles with new inputs and s=1 -> outputs and status unchanged.
- Branch: pc_in = 32'h20, signed_imm_24 = 24'hFFFFFE, b=1 -> branch_taken = 1, branch_addr = 32'h18 in the same cycle.
